id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline register of the RV32I 5-stage core. Captures decoded operands and control from the decode stage and presents registered A/B operands plus the logic-function select to the execute-stage ALU/logical unit. Supports stall (hold), flush (bubble), and write-back capture so that operands held during a stall see the newest register-file value. Also keeps saturating stall and flush event counters for performance debug.

Parameters:
size, 32, datapath width of operands, PC and immediate
reg_addr_w, 5, register index width
cnt_w, 16, width of the stall and flush event counters

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
stall  input  1  hold current contents (from hazard unit)
flush  input  1  replace contents with a bubble (branch or jump taken)
in_valid  input  1  decode stage holds a real instruction
in_pc  input  size  PC of the decoded instruction
in_rs1_data  input  size  register-file read port 1
in_rs2_data  input  size  register-file read port 2
in_imm  input  size  sign-extended immediate
in_rs1  input  reg_addr_w  source index 1
in_rs2  input  reg_addr_w  source index 2
in_rd  input  reg_addr_w  destination index
in_use_imm  input  1  B operand comes from the immediate
in_logic_sel  input  2  logical-unit function: 00 xor, 01 or, 10 and, 11 zero
in_unit_sel  input  2  execute result select (adder/shifter/logic/compare)
in_reg_write  input  1  instruction writes rd
in_mem_read  input  1  load
in_mem_write  input  1  store
wb_we  input  1  write-back stage is writing the register file this cycle
wb_rd  input  reg_addr_w  write-back destination
wb_data  input  size  write-back value
out_valid  output  1  execute stage holds a real instruction
out_pc  output  size  registered PC
out_A  output  size  registered ALU operand A (rs1 value)
out_B  output  size  registered ALU operand B (imm or rs2 value)
out_rs2_data  output  size  registered rs2 value (store data)
out_rs1, out_rs2, out_rd  output  reg_addr_w  registered indices (for forwarding unit)
out_logic_sel  output  2  registered logic select
out_unit_sel  output  2  registered unit select
out_reg_write, out_mem_read, out_mem_write  output  1 each  registered control
stall_count  output  cnt_w  cycles stalled while valid, saturating
flush_count  output  cnt_w  flushes that removed a valid instruction, saturating

Behaviour:
- Update priority per edge: reset > flush > stall > load.
- reset: every output and all internal state go to 0. Counters go to 0.
- flush: out_valid, out_reg_write, out_mem_read and out_mem_write go to 0. All data, index and select outputs go to 0. If out_valid was 1, flush_count increments. flush overrides a simultaneous stall.
- stall (no flush): all outputs hold. Exception: if out_valid=1, wb_we=1, wb_rd!=0 and wb_rd==out_rs1, then out_A is replaced by wb_data. The same rule applies for out_rs2: out_rs2_data takes wb_data, and out_B takes wb_data only when the held use_imm=0. Internally register use_imm for this purpose. stall_count increments when out_valid=1.
- load (neither flush nor stall): capture all inputs in one cycle, latency 1.
  - rs1 value = (wb_we && wb_rd!=0 && wb_rd==in_rs1) ? wb_data : in_rs1_data. rs2 value uses the same rule.
  - out_A = rs1 value; out_rs2_data = rs2 value; out_B = in_use_imm ? in_imm : rs2 value.
- load with in_valid=0: bubble. Same result as flush, but flush_count does not change.
- Register x0: wb_rd==0 never captures, so out_A stays as supplied by decode.
- Counters saturate at 2^cnt_w-1 and do not wrap.
- Reset asserted during stall or flush: reset wins and all state clears in that cycle.

Test Plan:
- Reset then load in_valid=1, rs1_data=0x0000_00F0, rs2_data=0x0000_0F0F, use_imm=0, logic_sel=00 -> next cycle out_valid=1, out_A=0x0000_00F0, out_B=0x0000_0F0F, out_logic_sel=00.
- Load with use_imm=1, imm=0xFFFF_FFFF, rs2_data=0x5 -> out_B=0xFFFF_FFFF, out_rs2_data=0x5.
- Load in_rs1=3 while wb_we=1, wb_rd=3, wb_data=0xDEAD_BEEF -> out_A=0xDEAD_BEEF. Repeat with wb_rd=0 and in_rs1=0 -> out_A=in_rs1_data.
- Hold valid instruction (rs2=7, use_imm=0) with stall=1 for 3 cycles; on cycle 2 wb_we=1, wb_rd=7, wb_data=0x1234 -> out_B and out_rs2_data become 0x1234, all other outputs unchanged, stall_count=3.
- Assert stall=1 and flush=1 together on a valid entry -> out_valid=0, out_reg_write=0, out_mem_write=0, flush_count +1, stall_count unchanged. Flush an already-empty entry -> flush_count unchanged.
- Force cnt_w=4, stall a valid entry for 20 cycles -> stall_count stops at 15. Assert reset mid-stall -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the RV32I 5-stage core.
// Holds the decoded operands and control that the execute stage consumes.
// Supports hold (stall), bubble insertion (flush), and write-back capture so
// that operands see the newest register-file value. Also keeps saturating
// stall and flush event counters for performance debug.
module id_ex_stage_reg #(
  parameter int size       = 32,
  parameter int reg_addr_w = 5,
  parameter int cnt_w      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [size-1:0]       in_pc,
  input  logic [size-1:0]       in_rs1_data,
  input  logic [size-1:0]       in_rs2_data,
  input  logic [size-1:0]       in_imm,
  input  logic [reg_addr_w-1:0] in_rs1,
  input  logic [reg_addr_w-1:0] in_rs2,
  input  logic [reg_addr_w-1:0] in_rd,
  input  logic                  in_use_imm,
  input  logic [1:0]            in_logic_sel,
  input  logic [1:0]            in_unit_sel,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  wb_we,
  input  logic [reg_addr_w-1:0] wb_rd,
  input  logic [size-1:0]       wb_data,
  output logic                  out_valid,
  output logic [size-1:0]       out_pc,
  output logic [size-1:0]       out_A,
  output logic [size-1:0]       out_B,
  output logic [size-1:0]       out_rs2_data,
  output logic [reg_addr_w-1:0] out_rs1,
  output logic [reg_addr_w-1:0] out_rs2,
  output logic [reg_addr_w-1:0] out_rd,
  output logic [1:0]            out_logic_sel,
  output logic [1:0]            out_unit_sel,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [cnt_w-1:0]      stall_count,
  output logic [cnt_w-1:0]      flush_count
);

  localparam logic [cnt_w-1:0] cnt_max = '1;

  // One pipeline entry. An all-zero entry is a bubble.
  typedef struct packed {
    logic                  valid;
    logic [size-1:0]       pc;
    logic [size-1:0]       a;
    logic [size-1:0]       b;
    logic [size-1:0]       rs2_data;
    logic [reg_addr_w-1:0] rs1;
    logic [reg_addr_w-1:0] rs2;
    logic [reg_addr_w-1:0] rd;
    logic                  use_imm;
    logic [1:0]            logic_sel;
    logic [1:0]            unit_sel;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } entry_t;

  entry_t           entry_q, entry_d;
  logic [cnt_w-1:0] stall_count_q, stall_count_d;
  logic [cnt_w-1:0] flush_count_q, flush_count_d;

  logic [size-1:0]  rs1_val, rs2_val;
  logic             wb_hit;
  logic             held_hit_rs1, held_hit_rs2;

  // Write-back capture: x0 is never a write target, so wb_rd==0 never matches.
  always_comb begin
    wb_hit       = wb_we && (wb_rd != '0);
    rs1_val      = (wb_hit && (wb_rd == in_rs1)) ? wb_data : in_rs1_data;
    rs2_val      = (wb_hit && (wb_rd == in_rs2)) ? wb_data : in_rs2_data;
    held_hit_rs1 = entry_q.valid && wb_hit && (wb_rd == entry_q.rs1);
    held_hit_rs2 = entry_q.valid && wb_hit && (wb_rd == entry_q.rs2);
  end

  // Next-state selection with priority flush > stall > load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    entry_d       = entry_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    if (flush) begin
      entry_d = '0;
      if (entry_q.valid && (flush_count_q != cnt_max)) begin
        flush_count_d = flush_count_q + cnt_w'(1);
      end
    end else if (stall) begin
      if (held_hit_rs1) begin
        entry_d.a = wb_data;
      end
      if (held_hit_rs2) begin
        entry_d.rs2_data = wb_data;
        if (!entry_q.use_imm) begin
          entry_d.b = wb_data;
        end
      end
      if (entry_q.valid && (stall_count_q != cnt_max)) begin
        stall_count_d = stall_count_q + cnt_w'(1);
      end
    end else if (!in_valid) begin
      entry_d = '0;
    end else begin
      entry_d.valid     = 1'b1;
      entry_d.pc        = in_pc;
      entry_d.a         = rs1_val;
      entry_d.b         = in_use_imm ? in_imm : rs2_val;
      entry_d.rs2_data  = rs2_val;
      entry_d.rs1       = in_rs1;
      entry_d.rs2       = in_rs2;
      entry_d.rd        = in_rd;
      entry_d.use_imm   = in_use_imm;
      entry_d.logic_sel = in_logic_sel;
      entry_d.unit_sel  = in_unit_sel;
      entry_d.reg_write = in_reg_write;
      entry_d.mem_read  = in_mem_read;
      entry_d.mem_write = in_mem_write;
    end
  end

  // State register with synchronous reset that overrides stall and flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      entry_q       <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      entry_q       <= entry_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign out_valid     = entry_q.valid;
  assign out_pc        = entry_q.pc;
  assign out_A         = entry_q.a;
  assign out_B         = entry_q.b;
  assign out_rs2_data  = entry_q.rs2_data;
  assign out_rs1       = entry_q.rs1;
  assign out_rs2       = entry_q.rs2;
  assign out_rd        = entry_q.rd;
  assign out_logic_sel = entry_q.logic_sel;
  assign out_unit_sel  = entry_q.unit_sel;
  assign out_reg_write = entry_q.reg_write;
  assign out_mem_read  = entry_q.mem_read;
  assign out_mem_write = entry_q.mem_write;
  assign stall_count   = stall_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// pipeline entry. Counters are built 4 bits wide to reach saturation.
module tb_id_ex_stage_reg;

  localparam int SIZE    = 32;
  localparam int RAW     = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            reset, stall, flush, in_valid;
  logic [SIZE-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [RAW-1:0]  in_rs1, in_rs2, in_rd;
  logic            in_use_imm;
  logic [1:0]      in_logic_sel, in_unit_sel;
  logic            in_reg_write, in_mem_read, in_mem_write;
  logic            wb_we;
  logic [RAW-1:0]  wb_rd;
  logic [SIZE-1:0] wb_data;

  logic            out_valid;
  logic [SIZE-1:0] out_pc, out_A, out_B, out_rs2_data;
  logic [RAW-1:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]      out_logic_sel, out_unit_sel;
  logic            out_reg_write, out_mem_read, out_mem_write;
  logic [CNT_W-1:0] stall_count, flush_count;

  id_ex_stage_reg #(.size(SIZE), .reg_addr_w(RAW), .cnt_w(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_use_imm(in_use_imm),
    .in_logic_sel(in_logic_sel), .in_unit_sel(in_unit_sel), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_A(out_A), .out_B(out_B),
    .out_rs2_data(out_rs2_data), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_logic_sel(out_logic_sel), .out_unit_sel(out_unit_sel),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: what the execute stage should be looking at.
  logic            m_valid, m_use_imm, m_rw, m_mr, m_mw;
  logic [SIZE-1:0] m_pc, m_a, m_b, m_rs2d;
  logic [RAW-1:0]  m_rs1, m_rs2, m_rd;
  logic [1:0]      m_lsel, m_usel;
  int              m_sc, m_fc;

  task automatic model_bubble();
    m_valid = 0; m_use_imm = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_pc = 0; m_a = 0; m_b = 0; m_rs2d = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_lsel = 0; m_usel = 0;
  endtask

  // Newest value of register r given decode-stage data and a concurrent write-back.
  function automatic logic [SIZE-1:0] newest(input logic [RAW-1:0] r, input logic [SIZE-1:0] d);
    if (wb_we && wb_rd != 0 && wb_rd == r) return wb_data;
    return d;
  endfunction

  task automatic model_step();
    if (reset) begin
      model_bubble();
      m_sc = 0; m_fc = 0;
    end else if (flush) begin
      if (m_valid) m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
      model_bubble();
    end else if (stall) begin
      if (m_valid) begin
        m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
        m_a = newest(m_rs1, m_a);
        m_rs2d = newest(m_rs2, m_rs2d);
        if (!m_use_imm) m_b = m_rs2d;
      end
    end else if (!in_valid) begin
      model_bubble();
    end else begin
      m_valid = 1; m_pc = in_pc;
      m_a = newest(in_rs1, in_rs1_data);
      m_rs2d = newest(in_rs2, in_rs2_data);
      m_b = in_use_imm ? in_imm : m_rs2d;
      m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
      m_use_imm = in_use_imm; m_lsel = in_logic_sel; m_usel = in_unit_sel;
      m_rw = in_reg_write; m_mr = in_mem_read; m_mw = in_mem_write;
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, m_valid);
    check("out_pc", out_pc, m_pc);
    check("out_A", out_A, m_a);
    check("out_B", out_B, m_b);
    check("out_rs2_data", out_rs2_data, m_rs2d);
    check("out_rs1", out_rs1, m_rs1);
    check("out_rs2", out_rs2, m_rs2);
    check("out_rd", out_rd, m_rd);
    check("out_logic_sel", out_logic_sel, m_lsel);
    check("out_unit_sel", out_unit_sel, m_usel);
    check("out_reg_write", out_reg_write, m_rw);
    check("out_mem_read", out_mem_read, m_mr);
    check("out_mem_write", out_mem_write, m_mw);
    check("stall_count", stall_count, m_sc[CNT_W-1:0]);
    check("flush_count", flush_count, m_fc[CNT_W-1:0]);
  endtask

  // Advance one clock: model sees the applied inputs, DUT sampled 1ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; in_valid = 0;
    in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_imm = 0;
    in_logic_sel = 0; in_unit_sel = 0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  initial begin
    model_bubble();
    m_sc = 0; m_fc = 0;
    idle_inputs();
    #2;

    // Reset state
    reset = 1;
    tick();
    check("reset_valid", out_valid, 0);
    reset = 0;

    // Plain load, B from rs2
    in_valid = 1; in_pc = 32'h100; in_rs1 = 1; in_rs2 = 2; in_rd = 3;
    in_rs1_data = 32'h0000_00F0; in_rs2_data = 32'h0000_0F0F; in_use_imm = 0;
    in_logic_sel = 2'b00; in_reg_write = 1;
    tick();
    check("load_A", out_A, 32'h0000_00F0);
    check("load_B", out_B, 32'h0000_0F0F);

    // Load with immediate B
    in_use_imm = 1; in_imm = 32'hFFFF_FFFF; in_rs2_data = 32'h5;
    tick();
    check("imm_B", out_B, 32'hFFFF_FFFF);
    check("imm_rs2_data", out_rs2_data, 32'h5);

    // Write-back capture at load, then x0 never captures
    in_use_imm = 0; in_rs1 = 3; wb_we = 1; wb_rd = 3; wb_data = 32'hDEAD_BEEF;
    tick();
    check("wb_fwd_A", out_A, 32'hDEAD_BEEF);
    in_rs1 = 0; wb_rd = 0; in_rs1_data = 32'hAAAA_0001;
    tick();
    check("x0_A", out_A, 32'hAAAA_0001);
    wb_we = 0;

    // Stall 3 cycles with write-back to held rs2 on the second
    reset = 1; tick(); reset = 0;
    in_rs1 = 2; in_rs2 = 7; in_use_imm = 0; in_rs2_data = 32'h77; tick();
    stall = 1; in_valid = 0; tick();
    wb_we = 1; wb_rd = 7; wb_data = 32'h1234; tick();
    wb_we = 0; tick();
    check("stall_B", out_B, 32'h1234);
    check("stall_rs2_data", out_rs2_data, 32'h1234);
    check("stall_count3", stall_count, 3);

    // Flush beats stall on a valid entry, then flush of an empty entry
    flush = 1; tick();
    check("flush_valid", out_valid, 0);
    check("flush_count1", flush_count, 1);
    check("flush_stall_cnt", stall_count, 3);
    tick();
    check("flush_empty_cnt", flush_count, 1);
    flush = 0;

    // Saturation of the stall counter, then reset mid-stall
    stall = 0; in_valid = 1; tick();
    stall = 1;
    for (int i = 0; i < 20; i++) tick();
    check("stall_sat", stall_count, CNT_MAX);
    reset = 1; tick();
    check("reset_mid_stall_cnt", stall_count, 0);
    check("reset_mid_stall_valid", out_valid, 0);
    idle_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      in_rs1       = RAW'($urandom_range(0, 3));
      in_rs2       = RAW'($urandom_range(0, 3));
      in_rd        = RAW'($urandom);
      in_use_imm   = 1'($urandom);
      in_logic_sel = 2'($urandom);
      in_unit_sel  = 2'($urandom);
      in_reg_write = 1'($urandom);
      in_mem_read  = 1'($urandom);
      in_mem_write = 1'($urandom);
      wb_we        = 1'($urandom);
      wb_rd        = RAW'($urandom_range(0, 3));
      wb_data      = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
